// File: rtl/fha_pkg.sv
// rtl/fha_pkg.sv - shared reset value and result type for the 1-bit full adder
package fha_pkg;

    // Reset value of every register in the adder block
    localparam logic FHA_RST_VAL = 1'b0;

    // Two-bit adder result, packed so that {carry,sum} equals the arithmetic sum
    typedef struct packed {
        logic carry;
        logic sum;
    } fha_result_t;

endpackage

// File: rtl/half_add_1bit.sv
// rtl/half_add_1bit.sv - 1-bit half adder cell
//   i_a, i_b : addends
//   o_sum    : i_a ^ i_b
//   o_carry  : i_a & i_b
module half_add_1bit
    import fha_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// File: rtl/full_half_add_1bit.sv
// rtl/full_half_add_1bit.sv - 1-bit full adder from two half adders, with registered copies
//   i_clk     : rising-edge clock
//   i_rst     : asynchronous active-high reset (clears registered outputs and o_err)
//   i_a, i_b  : addends
//   i_cin     : carry-in
//   o_sum     : combinational sum
//   o_carry   : combinational carry
//   o_sum_q   : o_sum delayed one cycle
//   o_carry_q : o_carry delayed one cycle
//   o_err     : sticky self-check flag, built only with FHA_SELF_CHECK_EN, else tied 0
module full_half_add_1bit
    import fha_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry,
    output logic o_sum_q,
    output logic o_carry_q,
    output logic o_err
);

    logic        w_s0;
    logic        w_c0;
    logic        w_c1;
    logic        w_sum;
    fha_result_t w_res;

    logic        r_sum_q;
    logic        r_carry_q;

    half_add_1bit u_ha0 (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_s0),
        .o_carry (w_c0)
    );

    half_add_1bit u_ha1 (
        .i_a     (w_s0),
        .i_b     (i_cin),
        .o_sum   (w_sum),
        .o_carry (w_c1)
    );

    // The two half-adder carries can never both be 1, so OR is exact
    assign w_res.sum   = w_sum;
    assign w_res.carry = w_c0 | w_c1;

    assign o_sum   = w_res.sum;
    assign o_carry = w_res.carry;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum_q   <= FHA_RST_VAL;
            r_carry_q <= FHA_RST_VAL;
        end else begin
            r_sum_q   <= w_res.sum;
            r_carry_q <= w_res.carry;
        end
    end

    assign o_sum_q   = r_sum_q;
    assign o_carry_q = r_carry_q;

`ifdef FHA_SELF_CHECK_EN
    // Arithmetic reference sum, compared against the half-adder result
    fha_result_t w_ref;
    logic        r_err;

    assign w_ref = fha_result_t'({1'b0, i_a} + {1'b0, i_b} + {1'b0, i_cin});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= FHA_RST_VAL;
        end else if (w_res != w_ref) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_half_add_1bit.sv
// tb/tb_full_half_add_1bit.sv - scoreboard bench for full_half_add_1bit (FHA_SELF_CHECK_EN aware)
module tb_full_half_add_1bit;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_a;
    logic i_b;
    logic i_cin;
    logic o_sum;
    logic o_carry;
    logic o_sum_q;
    logic o_carry_q;
    logic o_err;

    full_half_add_1bit u_dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_cin     (i_cin),
        .o_sum     (o_sum),
        .o_carry   (o_carry),
        .o_sum_q   (o_sum_q),
        .o_carry_q (o_carry_q),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0] comb;   // expected {carry,sum} of the inputs just driven
        logic [1:0] regd;   // expected {carry_q,sum_q} after the edge just passed
        int         idx;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] held;       // {carry,sum} of the inputs the DUT sees at the next edge
    logic       exp_err = 1'b0;
    int         vec_idx = 0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_add(input logic a, input logic b, input logic c);
        int tot;
        tot = int'(a) + int'(b) + int'(c);
        return tot[1:0];
    endfunction

    // Drive one vector just after an edge and queue what the monitor must see
    task automatic apply(input logic a, input logic b, input logic c);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_a   = a;
        i_b   = b;
        i_cin = c;
        e.comb = ref_add(a, b, c);
        e.regd = held;
        e.idx  = vec_idx;
        vec_idx++;
        held = e.comb;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(posedge i_clk);
            guard++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
    endtask

    // Monitor: compare on the falling edge, away from the capture edge
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check($sformatf("comb[%0d]", e.idx), {o_carry, o_sum}, e.comb);
                check($sformatf("reg[%0d]", e.idx), {o_carry_q, o_sum_q}, e.regd);
                check($sformatf("err[%0d]", e.idx), {1'b0, o_err}, {1'b0, exp_err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_a   = 1'b0;
        i_b   = 1'b0;
        i_cin = 1'b0;
        #12;
        check("reset_regs", {o_carry_q, o_sum_q}, 2'b00);
        check("reset_err", {1'b0, o_err}, 2'b00);
        check("reset_comb", {o_carry, o_sum}, 2'b00);
        @(negedge i_clk);
        i_rst = 1'b0;
        held  = ref_add(1'b0, 1'b0, 1'b0);

        // Exhaustive sweep
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            apply(v[2], v[1], v[0]);
        end

        // Random vectors
        for (int i = 0; i < 100; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        // Latency: registered outputs lag by exactly one edge
        @(posedge i_clk);
        #1;
        i_a = 1'b0; i_b = 1'b0; i_cin = 1'b0;
        @(posedge i_clk);
        #1;
        i_a = 1'b1; i_b = 1'b1; i_cin = 1'b1;
        #1;
        check("lat_comb", {o_carry, o_sum}, 2'b11);
        check("lat_before", {o_carry_q, o_sum_q}, 2'b00);
        @(posedge i_clk);
        #1;
        check("lat_after", {o_carry_q, o_sum_q}, 2'b11);

        // Asynchronous reset between edges
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_regs", {o_carry_q, o_sum_q}, 2'b00);
        check("arst_comb", {o_carry, o_sum}, 2'b11);
        i_a = 1'b1; i_b = 1'b0; i_cin = 1'b0;
        #1;
        check("arst_comb2", {o_carry, o_sum}, 2'b01);
        @(posedge i_clk);
        #1;
        check("arst_hold", {o_carry_q, o_sum_q}, 2'b00);

        // Release: first capture on the first edge after deassertion
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rel_before", {o_carry_q, o_sum_q}, 2'b00);
        @(posedge i_clk);
        #1;
        check("rel_after", {o_carry_q, o_sum_q}, 2'b01);
        held = 2'b01;

        for (int i = 0; i < 20; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

`ifdef FHA_SELF_CHECK_EN
        @(posedge i_clk);
        #1;
        i_a = 1'b0; i_b = 1'b0; i_cin = 1'b0;
        force u_dut.w_c1 = 1'b1;
        @(posedge i_clk);
        #1;
        check("err_set", {1'b0, o_err}, 2'b01);
        release u_dut.w_c1;
        @(posedge i_clk);
        #1;
        check("err_sticky", {1'b0, o_err}, 2'b01);
        i_rst = 1'b1;
        #1;
        check("err_clear", {1'b0, o_err}, 2'b00);
        @(negedge i_clk);
        i_rst = 1'b0;
`else
        @(posedge i_clk);
        #1;
        check("err_tied", {1'b0, o_err}, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
